// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's ibus/dbus, the arbiter and the single-port RAM.
// slave = arbiter side, master = core/RAM side.
interface mem_arbiter_if #(
  parameter int AW = 22
);
  logic          ibus_req;
  logic [AW-1:0] ibus_addr;
  logic          ibus_ready;
  logic          ibus_rvalid;
  logic [31:0]   ibus_rdata;

  logic          dbus_req;
  logic          dbus_write;
  logic [AW-1:0] dbus_addr;
  logic [31:0]   dbus_wdata;
  logic [3:0]    dbus_wstrb;
  logic          dbus_ready;
  logic          dbus_rvalid;
  logic [31:0]   dbus_rdata;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  ibus_req, ibus_addr,
    output ibus_ready, ibus_rvalid, ibus_rdata,
    input  dbus_req, dbus_write, dbus_addr, dbus_wdata, dbus_wstrb,
    output dbus_ready, dbus_rvalid, dbus_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ibus_req, ibus_addr,
    input  ibus_ready, ibus_rvalid, ibus_rdata,
    output dbus_req, dbus_write, dbus_addr, dbus_wdata, dbus_wstrb,
    input  dbus_ready, dbus_rvalid, dbus_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (ibus fetch / dbus load-store) arbiter for the single-port RAM.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int AW           = 22,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst_b,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic i_win;
  logic d_win;
  logic starve_force;
  logic rd_pend;
  logic rd_owner;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign starve_force = (starve_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      starve_cnt <= '0;
    end else if (i_win) begin
      starve_cnt <= '0;
    end else if (bus.ibus_req && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (rst_b) begin
      i_win = bus.ibus_req && (!bus.dbus_req || starve_force);
      d_win = bus.dbus_req && !i_win;
    end
  end

  assign bus.ibus_ready = i_win;
  assign bus.dbus_ready = d_win;

  assign bus.mem_en    = i_win || d_win;
  assign bus.mem_addr  = d_win ? bus.dbus_addr[AW-1:2] : bus.ibus_addr[AW-1:2];
  assign bus.mem_we    = (d_win && bus.dbus_write) ? bus.dbus_wstrb : 4'b0000;
  assign bus.mem_wdata = bus.dbus_wdata;

  // Owner of the read data that the RAM returns in the following cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= i_win || (d_win && !bus.dbus_write);
      rd_owner <= d_win && !bus.dbus_write;
    end
  end

  assign bus.ibus_rvalid = rd_pend && !rd_owner;
  assign bus.dbus_rvalid = rd_pend && rd_owner;
  assign bus.ibus_rdata  = bus.ibus_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.dbus_rdata  = bus.dbus_rvalid ? bus.mem_rdata : 32'h0;

  // Byte offset is meaningless to a word RAM; LIMIT is idle without the guard.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.ibus_addr[1:0], bus.dbus_addr[1:0], LIMIT};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed sequences, a vector table and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW    = 22;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] t;
    if (a == 32'h40) return 32'hCAFE0040;
    if (a == 32'h80) return 32'h11223344;
    t = 32'(a) * 32'h01000193;
    return t ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM environment: synchronous read of the old word, byte-masked write.
  logic [31:0] ram [0:255];
  bit   [255:0] ram_wr = '0;

  function automatic logic [31:0] ram_rd(input int a);
    return ram_wr[a] ? ram[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= ram_rd(int'(bus.mem_addr[7:0]));
      if (|bus.mem_we) begin
        ram[bus.mem_addr[7:0]]    <= merge(ram_rd(int'(bus.mem_addr[7:0])), bus.mem_wdata, bus.mem_we);
        ram_wr[bus.mem_addr[7:0]] <= 1'b1;
      end
    end
  end

  // Reference model: who wins this cycle, and what the next response should be.
  logic [31:0] ref_mem [0:255];
  bit   [255:0] ref_wr = '0;
  bit          m_pend  = 1'b0;
  bit          m_owner = 1'b0;
  bit   [31:0] m_data  = '0;
  int          m_starve = 0;
  logic        e_gi;
  logic        e_gd;

  function automatic logic [31:0] ref_rd(input int a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

`ifdef MEM_ARB_STARVE_GUARD_EN
  assign e_gi = rst_b && bus.ibus_req && (!bus.dbus_req || (m_starve >= LIMIT));
`else
  assign e_gi = rst_b && bus.ibus_req && !bus.dbus_req;
`endif
  assign e_gd = rst_b && bus.dbus_req && !e_gi;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_pend   <= 1'b0;
      m_owner  <= 1'b0;
      m_starve <= 0;
    end else begin
      m_pend  <= e_gi || (e_gd && !bus.dbus_write);
      m_owner <= e_gd;
      if (e_gi)
        m_data <= ref_rd(int'(bus.ibus_addr[9:2]));
      else if (e_gd)
        m_data <= ref_rd(int'(bus.dbus_addr[9:2]));
      if (e_gd && bus.dbus_write) begin
        ref_mem[bus.dbus_addr[9:2]] <= merge(ref_rd(int'(bus.dbus_addr[9:2])), bus.dbus_wdata, bus.dbus_wstrb);
        ref_wr[bus.dbus_addr[9:2]]  <= 1'b1;
      end
      if (e_gi)
        m_starve <= 0;
      else if (bus.ibus_req)
        m_starve <= m_starve + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 64'({bus.ibus_ready, bus.dbus_ready}), 64'({e_gi, e_gd}));
      check("mem_en", 64'(bus.mem_en), 64'(e_gi || e_gd));
      check("mem_we", 64'(bus.mem_we), 64'((e_gd && bus.dbus_write) ? bus.dbus_wstrb : 4'h0));
      if (e_gi || e_gd)
        check("mem_addr", 64'(bus.mem_addr),
              64'(e_gd ? bus.dbus_addr[AW-1:2] : bus.ibus_addr[AW-1:2]));
      if (e_gd && bus.dbus_write)
        check("mem_wdata", 64'(bus.mem_wdata), 64'(bus.dbus_wdata));
      check("ibus_resp", 64'({bus.ibus_rvalid, bus.ibus_rdata}),
            64'({m_pend && !m_owner, (m_pend && !m_owner) ? m_data : 32'h0}));
      check("dbus_resp", 64'({bus.dbus_rvalid, bus.dbus_rdata}),
            64'({m_pend && m_owner, (m_pend && m_owner) ? m_data : 32'h0}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ibus_req   = 1'b0;
    bus.dbus_req   = 1'b0;
    bus.dbus_write = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  typedef struct {
    bit          ireq;
    logic [21:0] iaddr;
    bit          dreq;
    bit          dwr;
    logic [21:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          e_ir;
    bit          e_dr;
    bit          e_en;
    logic [3:0]  e_we;
    logic [19:0] e_addr;
  } vec_t;

  vec_t vt [8];
  bit   acc_i;
  bit   acc_d;
  bit   exp_ir;

  initial begin
    vt[0] = '{0, 22'h000, 0, 0, 22'h000, 32'h0,        4'h0, 0, 0, 0, 4'h0, 20'h00};
    vt[1] = '{1, 22'h084, 0, 0, 22'h000, 32'h0,        4'h0, 1, 0, 1, 4'h0, 20'h21};
    vt[2] = '{0, 22'h000, 1, 0, 22'h088, 32'h0,        4'h0, 0, 1, 1, 4'h0, 20'h22};
    vt[3] = '{0, 22'h000, 1, 1, 22'h08C, 32'h12345678, 4'hF, 0, 1, 1, 4'hF, 20'h23};
    vt[4] = '{1, 22'h094, 1, 0, 22'h090, 32'h0,        4'h0, 0, 1, 1, 4'h0, 20'h24};
    vt[5] = '{1, 22'h097, 0, 0, 22'h000, 32'h0,        4'h0, 1, 0, 1, 4'h0, 20'h25};
    vt[6] = '{1, 22'h09C, 1, 1, 22'h098, 32'hA1B2C3D4, 4'h5, 0, 1, 1, 4'h5, 20'h26};
    vt[7] = '{0, 22'h000, 1, 1, 22'h0A0, 32'hFFFFFFFF, 4'h0, 0, 1, 1, 4'h0, 20'h28};

    bus.ibus_req   = 1'b1;
    bus.ibus_addr  = 22'h100;
    bus.dbus_req   = 1'b1;
    bus.dbus_write = 1'b0;
    bus.dbus_addr  = 22'h200;
    bus.dbus_wdata = 32'h0;
    bus.dbus_wstrb = 4'h0;
    rst_b  = 1'b0;
    chk_en = 1'b1;

    // Reset held with both requesting, then a single fetch right after release.
    @(negedge clk);
    check("rst_outputs", 64'({bus.ibus_ready, bus.dbus_ready, bus.mem_en, bus.mem_we,
                              bus.ibus_rvalid, bus.dbus_rvalid}), 64'h0);
    check("rst_rdata", 64'({bus.ibus_rdata, bus.dbus_rdata}), 64'h0);
    tick();
    rst_b = 1'b1;
    bus.dbus_req = 1'b0;
    @(negedge clk);
    check("fetch_ready", 64'(bus.ibus_ready), 64'h1);
    check("fetch_addr", 64'(bus.mem_addr), 64'h40);
    tick();
    idle();
    @(negedge clk);
    check("fetch_resp", 64'({bus.ibus_rvalid, bus.ibus_rdata}), 64'({1'b1, 32'hCAFE0040}));
    check("fetch_no_dvalid", 64'(bus.dbus_rvalid), 64'h0);

    // Partial store then load of the same word.
    tick();
    bus.dbus_req   = 1'b1;
    bus.dbus_write = 1'b1;
    bus.dbus_addr  = 22'h200;
    bus.dbus_wdata = 32'hDEADBEEF;
    bus.dbus_wstrb = 4'h3;
    @(negedge clk);
    check("store_we", 64'({bus.dbus_ready, bus.mem_we}), 64'({1'b1, 4'h3}));
    tick();
    bus.dbus_write = 1'b0;
    @(negedge clk);
    check("store_no_rvalid", 64'(bus.dbus_rvalid), 64'h0);
    tick();
    idle();
    @(negedge clk);
    check("load_after_store", 64'({bus.dbus_rvalid, bus.dbus_rdata}), 64'({1'b1, 32'h1122BEEF}));

    // Interleaved pipeline ibus / dbus / ibus.
    tick();
    bus.ibus_req  = 1'b1;
    bus.ibus_addr = 22'h100;
    tick();
    bus.ibus_req  = 1'b0;
    bus.dbus_req  = 1'b1;
    bus.dbus_addr = 22'h204;
    @(negedge clk);
    check("il_c1_i", 64'({bus.ibus_rvalid, bus.ibus_rdata}), 64'({1'b1, 32'hCAFE0040}));
    check("il_c1_d", 64'(bus.dbus_rvalid), 64'h0);
    tick();
    bus.dbus_req  = 1'b0;
    bus.ibus_req  = 1'b1;
    bus.ibus_addr = 22'h108;
    @(negedge clk);
    check("il_c2_d", 64'({bus.dbus_rvalid, bus.dbus_rdata}), 64'({1'b1, init_word(32'h81)}));
    check("il_c2_i", 64'(bus.ibus_rvalid), 64'h0);
    tick();
    idle();
    @(negedge clk);
    check("il_c3_i", 64'({bus.ibus_rvalid, bus.ibus_rdata}), 64'({1'b1, init_word(32'h42)}));
    check("il_c3_d", 64'(bus.dbus_rvalid), 64'h0);

    // Reset lands between a read's acceptance and its response.
    tick();
    bus.ibus_req  = 1'b1;
    bus.ibus_addr = 22'h100;
    @(negedge clk);
    check("midrst_accept", 64'(bus.ibus_ready), 64'h1);
    #1;
    rst_b = 1'b0;
    bus.ibus_req = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_rvalid", 64'({bus.ibus_rvalid, bus.dbus_rvalid}), 64'h0);
      tick();
    end

    // Sustained contention, starting from a cleared starvation count.
    do_reset();
    bus.ibus_req  = 1'b1;
    bus.ibus_addr = 22'h010;
    bus.dbus_req  = 1'b1;
    bus.dbus_addr = 22'h020;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_ir = (c % 5 == 0);
`else
      exp_ir = 1'b0;
`endif
      check($sformatf("contend_c%0d", c), 64'({bus.ibus_ready, bus.dbus_ready}),
            64'({exp_ir, !exp_ir}));
      tick();
    end
    idle();

    // Vector table, one record per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.ibus_req   = vt[i].ireq;
      bus.ibus_addr  = vt[i].iaddr;
      bus.dbus_req   = vt[i].dreq;
      bus.dbus_write = vt[i].dwr;
      bus.dbus_addr  = vt[i].daddr;
      bus.dbus_wdata = vt[i].wdata;
      bus.dbus_wstrb = vt[i].wstrb;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 64'({bus.ibus_ready, bus.dbus_ready}),
            64'({vt[i].e_ir, vt[i].e_dr}));
      check($sformatf("vec%0d_en_we", i), 64'({bus.mem_en, bus.mem_we}),
            64'({vt[i].e_en, vt[i].e_we}));
      if (vt[i].e_en)
        check($sformatf("vec%0d_addr", i), 64'(bus.mem_addr), 64'(vt[i].e_addr));
      tick();
    end
    idle();

    // Randomized traffic with hold-until-accepted requesters and rare resets.
    acc_i = 1'b0;
    acc_d = 1'b0;
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst_b = ($urandom_range(0, 199) != 0);
      if (!bus.ibus_req || acc_i) begin
        bus.ibus_req  = ($urandom_range(0, 3) != 0);
        bus.ibus_addr = 22'($urandom_range(0, 63));
      end
      if (!bus.dbus_req || acc_d) begin
        bus.dbus_req   = ($urandom_range(0, 3) != 0);
        bus.dbus_write = ($urandom_range(0, 2) == 0);
        bus.dbus_addr  = 22'($urandom_range(0, 63));
        bus.dbus_wdata = $urandom;
        bus.dbus_wstrb = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      acc_i = bus.ibus_ready;
      acc_d = bus.dbus_ready;
      tick();
    end
    rst_b = 1'b1;
    idle();
    tick();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
